seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It holds a shadow copy of DIGITS hex nibbles plus per-digit decimal-point and blank flags. A prescaled scan counter selects one digit per slot and drives the shared segment bus and one-hot anode select. Each digit slot starts with one dead cycle to suppress ghosting. The block sits between the game/score logic and the board display pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8).
SCAN_CNT, 50000, clock cycles per digit slot (>=2); frame period = DIGITS*SCAN_CNT.
SEG_ACTIVE_LOW, 1, 1: segment/dp lit when 0; 0: lit when 1.
AN_ACTIVE_LOW, 1, 1: digit enabled when its an bit is 0; 0: enabled when 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
data  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) feeds digit i, digit 0 rightmost.
dp  input  DIGITS  decimal point request per digit, 1 = lit.
blank  input  DIGITS  per-digit blank request, 1 = digit dark.
load  input  1  1-cycle strobe; captures data/dp/blank into shadow registers.
seg  output  7  segments {g,f,e,d,c,b,a}, bit 6 = g.
dp_out  output  1  decimal point segment.
an  output  DIGITS  digit enables.

Behaviour:
- Reset (async assert, sync release): shadow data/dp/blank = 0, prescaler cnt = 0, digit index idx = 0. seg, dp_out and an go to the inactive level: all-off pattern per polarity (SEG_ACTIVE_LOW=1 -> seg=7'h7F, dp_out=1; AN_ACTIVE_LOW=1 -> an all 1s).
- Shadow: on a clk edge with load=1, shadow <= {data,dp,blank}. Without load the shadow holds. The live inputs never reach the outputs directly.
- Prescaler: cnt counts 0..SCAN_CNT-1. On cnt==SCAN_CNT-1, cnt -> 0 and idx -> idx+1. idx wraps from DIGITS-1 to 0.
- Outputs are registered each cycle from the pre-edge cnt, idx and shadow, giving 1-cycle latency.
- Dead cycle: if cnt==0, an = all inactive and seg/dp_out = off.
- Otherwise (active cycle):
  - an = one-hot idx at the active level.
  - seg = hex decode of shadow nibble idx, or all-off if shadow blank[idx]=1.
  - dp_out = shadow dp[idx] (off if blanked).
- Active-low hex codes {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. With SEG_ACTIVE_LOW=0 these codes and dp_out are bit-inverted.
- Per slot: 1 dead cycle then SCAN_CNT-1 lit cycles. At most one an bit is ever active.
- load coincident with a slot change: the new shadow is used from the next cycle's output computation. There is no tearing within a cycle.
- Reset mid-scan: outputs go inactive immediately. Scan restarts at digit 0, cnt 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit i>0 is auto-blanked when shadow nibble i and all higher nibbles are 0 and none of those digits has dp set. Digit 0 is never auto-blanked. The explicit blank input still applies.
- Undefined: zeros are always displayed unless the blank flag is set.

Test Plan:
- DIGITS=4, SCAN_CNT=4, both polarities active-low. Hold rst_n=0 -> seg=7'h7F, dp_out=1, an=4'hF. Then release rst_n; the first output cycle is dead (an=4'hF).
- load with data=16'h12AF, dp=0, blank=0 -> per frame: an=1110 with seg=0001110 (F), an=1101 with seg=0001000 (A), an=1011 with seg=0100100 (2), an=0111 with seg=1111001 (1). Each is lit 3 cycles, separated by 1 dead cycle with an=1111.
- Change data to 16'h0000 without load -> display unchanged. Pulse load -> all slots show seg=1000000 from the next cycle.
- Set blank=4'b0100 and dp=4'b0001, then load -> digit 2 has seg=7'h7F with an=1011; digit 0 has dp_out=0 with an=1110.
- Sweep data 0..F in digit 0 -> seg matches the table. With SEG_ACTIVE_LOW=0, seg is the bitwise inverse, e.g. 8 -> 7'h7F.
- With LEADING_ZERO_BLANK_EN defined, load data=16'h0070 -> digits 3 and 1... digits 3 and 2 dark, digit 1 shows 7 (1111000), digit 0 shows 0 (1000000). Assert rst_n=0 mid-slot -> an=4'hF asynchronously.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver
// Optional: LEADING_ZERO_BLANK_EN auto-blanks leading zero digits (digit 0 excluded).
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_CNT       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = $clog2(SCAN_CNT);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic [3:0]          nib;
    logic                cur_dp;
    logic                cur_dark;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   lz;
    logic [6:0]          seg_low;
    logic                dp_low;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic [DIGITS-1:0]   an_n;

    // Codes are active-low {g..a}; polarity is applied after selection.
    function automatic logic [6:0] hex_al(input logic [3:0] v);
        case (v)
            4'h0: hex_al = 7'b1000000;
            4'h1: hex_al = 7'b1111001;
            4'h2: hex_al = 7'b0100100;
            4'h3: hex_al = 7'b0110000;
            4'h4: hex_al = 7'b0011001;
            4'h5: hex_al = 7'b0010010;
            4'h6: hex_al = 7'b0000010;
            4'h7: hex_al = 7'b1111000;
            4'h8: hex_al = 7'b0000000;
            4'h9: hex_al = 7'b0010000;
            4'hA: hex_al = 7'b0001000;
            4'hB: hex_al = 7'b0000011;
            4'hC: hex_al = 7'b1000110;
            4'hD: hex_al = 7'b0100001;
            4'hE: hex_al = 7'b0000110;
            default: hex_al = 7'b0001110;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit goes dark while it and every digit above it is a zero without dp.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz       = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (sh_data[4*i +: 4] == 4'h0) & ~sh_dp[i];
            lz[i]    = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib      = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = sh_data[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_dark  = sh_blank[i] | lz[i];
                an_sel[i] = 1'b1;
            end
        end
        seg_low = cur_dark ? 7'h7F : hex_al(nib);
        dp_low  = cur_dark | ~cur_dp;
        if (cnt == '0) begin
            seg_n = SEG_OFF;
            dp_n  = DP_OFF;
            an_n  = AN_OFF;
        end else begin
            seg_n = (SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low;
            dp_n  = (SEG_ACTIVE_LOW != 0) ? dp_low  : ~dp_low;
            an_n  = AN_OFF ^ an_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            cnt      <= '0;
            idx      <= '0;
            seg      <= SEG_OFF;
            dp_out   <= DP_OFF;
            an       <= AN_OFF;
        end else begin
            if (load) begin
                sh_data  <= data;
                sh_dp    <= dp;
                sh_blank <= blank;
            end
            if (cnt == CW'(SCAN_CNT - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg    <= seg_n;
            dp_out <= dp_n;
            an     <= an_n;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized model-checked bench for seg7_scan_driver
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   data = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blank = '0;
    logic          load = 1'b0;
    logic [6:0]    seg0, seg1;
    logic          dpo0, dpo1;
    logic [3:0]    an0, an1;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg7_scan_driver #(.DIGITS(ND), .SCAN_CNT(SC), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .load(load),
        .seg(seg0), .dp_out(dpo0), .an(an0));

    seg7_scan_driver #(.DIGITS(ND), .SCAN_CNT(SC), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .load(load),
        .seg(seg1), .dp_out(dpo1), .an(an1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: position in the frame follows from the edge count since reset.
    int          t;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;

    function automatic bit auto_dark(input int i, input logic [15:0] d, input logic [3:0] p);
`ifdef LEADING_ZERO_BLANK_EN
        return (i > 0) && ((d >> (4 * i)) == 0) && ((p >> i) == 0);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_data = '0; m_dp = '0; m_blank = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            int p, mc, mi;
            bit dark;
            p  = t % (ND * SC);
            mc = p % SC;
            mi = p / SC;
            if (mc == 0) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
            end else begin
                dark  = m_blank[mi] || auto_dark(mi, m_data, m_dp);
                e_an  = ~(4'b0001 << mi);
                e_seg = dark ? 7'h7F : hex_tab[(m_data >> (4 * mi)) & 16'hF];
                e_dp  = dark ? 1'b1 : ~m_dp[mi];
            end
            if (load) begin
                m_data = data; m_dp = dp; m_blank = blank;
            end
            t++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("seg_al", {25'd0, seg0}, {25'd0, e_seg});
            chk("dp_al", {31'd0, dpo0}, {31'd0, e_dp});
            chk("an_al", {28'd0, an0}, {28'd0, e_an});
            chk("seg_ah", {25'd0, seg1}, {25'd0, ~e_seg});
            chk("dp_ah", {31'd0, dpo1}, {31'd0, ~e_dp});
            chk("an_ah", {28'd0, an1}, {28'd0, ~e_an});
        end
    end

    task automatic wait_an(input logic [3:0] pat, input string name);
        int n = 0;
        @(negedge clk);
        while (an0 !== pat && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_reach"}, {28'd0, an0}, {28'd0, pat});
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data = d; dp = p; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int run;
        repeat (2) @(negedge clk);
        chk("rst_seg", {25'd0, seg0}, 32'h7F);
        chk("rst_dp", {31'd0, dpo0}, 32'h1);
        chk("rst_an", {28'd0, an0}, 32'hF);
        chk("rst_an_ah", {28'd0, an1}, 32'h0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_dead", {28'd0, an0}, 32'hF);

        do_load(16'h12AF, 4'h0, 4'h0);
        wait_an(4'hF, "dead");
        wait_an(4'b1110, "d0");
        chk("d0_F", {25'd0, seg0}, {25'd0, 7'b0001110});
        run = 1;
        while (run < 10) begin
            @(negedge clk);
            if (an0 !== 4'b1110) break;
            run++;
        end
        chk("lit_len", run, 3);
        chk("gap_dead", {28'd0, an0}, 32'hF);
        wait_an(4'b1101, "d1");
        chk("d1_A", {25'd0, seg0}, {25'd0, 7'b0001000});
        wait_an(4'b1011, "d2");
        chk("d2_2", {25'd0, seg0}, {25'd0, 7'b0100100});
        wait_an(4'b0111, "d3");
        chk("d3_1", {25'd0, seg0}, {25'd0, 7'b1111001});

        data = 16'h0000;
        repeat (20) @(negedge clk);
        wait_an(4'b1101, "hold");
        chk("hold_A", {25'd0, seg0}, {25'd0, 7'b0001000});
        do_load(16'h0000, 4'h0, 4'h0);
        wait_an(4'b1110, "z0");
        chk("z0", {25'd0, seg0}, {25'd0, 7'b1000000});

        do_load(16'h1234, 4'b0001, 4'b0100);
        wait_an(4'b1011, "blk");
        chk("blk_seg", {25'd0, seg0}, 32'h7F);
        wait_an(4'b1110, "dpd");
        chk("dp_lit", {31'd0, dpo0}, 32'h0);
        chk("dp_seg4", {25'd0, seg0}, {25'd0, 7'b0011001});

        for (int v = 0; v < 16; v++) begin
            do_load(16'(v), 4'h0, 4'h0);
            wait_an(4'b1110, "sweep");
            chk("sweep_al", {25'd0, seg0}, {25'd0, hex_tab[v]});
            chk("sweep_ah", {25'd0, seg1}, {25'd0, ~hex_tab[v]});
        end
        do_load(16'h0008, 4'h0, 4'h0);
        wait_an(4'b1110, "eight");
        chk("eight_ah", {25'd0, seg1}, 32'h7F);

        do_load(16'h0070, 4'h0, 4'h0);
        wait_an(4'b1101, "lz1");
        chk("lz_d1", {25'd0, seg0}, {25'd0, 7'b1111000});
        wait_an(4'b0111, "lz3");
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_d3", {25'd0, seg0}, 32'h7F);
`else
        chk("lz_d3", {25'd0, seg0}, {25'd0, 7'b1000000});
`endif

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) begin
                data = 16'($urandom);
                dp = 4'($urandom);
                blank = 4'($urandom_range(3) == 0 ? $urandom : 0);
                if ($urandom_range(1) == 0) data[15:8] = 8'h00;
                load = 1'b1;
            end else begin
                load = 1'b0;
                data = 16'($urandom);
            end
            @(negedge clk);
        end
        load = 1'b0;

        wait_an(4'b1101, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {28'd0, an0}, 32'hF);
        chk("async_seg", {25'd0, seg0}, 32'h7F);
        chk("async_an_ah", {28'd0, an1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_dead", {28'd0, an0}, 32'hF);
        @(negedge clk);
        chk("restart_d0", {28'd0, an0}, {28'd0, 4'b1110});
        chk("restart_seg", {25'd0, seg0}, {25'd0, 7'b1000000});
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
